// File: rtl/fsin_sync_gen.sv
// Frame-sync (FSIN) pulse generator: programmable period/width, free-run, trigger and burst modes.
// Define FSIN_TIMESTAMP_EN to add a 32-bit rise timestamp (ts_o, ts_valid_o).
module fsin_sync_gen #(
  parameter int CNT_W      = 24,
  parameter int PERIOD_DEF = 1200000,
  parameter int WIDTH_DEF  = 4800,
  parameter int BURST_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [1:0]         mode_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [CNT_W-1:0]   width_i,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               cfg_load_i,
  input  logic               trig_i,
  output logic               fsin_o,
  output logic               busy_o,
  output logic [31:0]        frame_cnt_o,
  output logic               cfg_err_o,
  output logic               trig_miss_o
`ifdef FSIN_TIMESTAMP_EN
  ,
  output logic [31:0]        ts_o,
  output logic               ts_valid_o
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_TRIG = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;
  localparam logic [1:0] LOW       = 2'd3;

  localparam logic [1:0] M_FREE  = 2'b00;
  localparam logic [1:0] M_TRIG  = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;

  typedef struct packed {
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   width;
    logic [BURST_W-1:0] burst;
  } cfg_t;

  localparam cfg_t CFG_RST = '{period: CNT_W'(PERIOD_DEF),
                               width:  CNT_W'(WIDTH_DEF),
                               burst:  BURST_W'(1)};

  logic [1:0]         state;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W-1:0] burst_rem;
  logic               burst_done;
  logic               stop_q;
  cfg_t               act, act_nx;
  cfg_t               pend, pend_nx;
  logic               pend_vld, pend_vld_nx;
  cfg_t               cfg_in;
  logic [2:0]         trig_pipe;
  logic               trig_rise;
  logic               idle_like;
  logic               hi_end;
  logic               lo_end;
  logic               cfg_bad;
  logic               cfg_ok;
  logic               rise;

  // trig_pipe[1:0] is the 2-FF synchronizer, [2] holds the previous synced level
  assign trig_rise = trig_pipe[1] & ~trig_pipe[2];

  assign idle_like = (state == IDLE) || (state == WAIT_TRIG);
  assign busy_o    = (state == HIGH) || (state == LOW);
  assign hi_end    = (state == HIGH) && (cnt == act.width - CNT_W'(1));
  assign lo_end    = (state == LOW)  && (cnt == act.period - CNT_W'(1));
  // fsin_o lags the FSM by one cycle, so the first HIGH cycle marks the rise
  assign rise      = (state == HIGH) && (cnt == '0);

  assign cfg_in  = '{period: period_i, width: width_i, burst: burst_i};
  assign cfg_bad = (period_i < CNT_W'(2)) || (width_i == '0) || (width_i >= period_i) ||
                   ((mode_i == M_BURST) && (burst_i == '0));
  assign cfg_ok  = cfg_load_i && !cfg_bad;

  // Pending config lands at a period boundary or as soon as the FSM is not running
  always_comb begin
    act_nx      = act;
    pend_nx     = pend;
    pend_vld_nx = pend_vld;
    if (pend_vld && (idle_like || lo_end)) begin
      act_nx      = pend;
      pend_vld_nx = 1'b0;
    end
    if (cfg_ok) begin
      if (idle_like) begin
        act_nx = cfg_in;
      end else begin
        pend_nx     = cfg_in;
        pend_vld_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= M_FREE;
      cnt         <= '0;
      burst_rem   <= '0;
      burst_done  <= 1'b0;
      stop_q      <= 1'b0;
      act         <= CFG_RST;
      pend        <= '0;
      pend_vld    <= 1'b0;
      trig_pipe   <= '0;
      fsin_o      <= 1'b0;
      frame_cnt_o <= '0;
      cfg_err_o   <= 1'b0;
      trig_miss_o <= 1'b0;
    end else begin
      trig_pipe <= {trig_pipe[1:0], trig_i};
      act       <= act_nx;
      pend      <= pend_nx;
      pend_vld  <= pend_vld_nx;
      fsin_o    <= (state == HIGH);

      if (rise)                 frame_cnt_o <= frame_cnt_o + 32'd1;
      if (cfg_load_i)           cfg_err_o   <= cfg_bad;
      if (trig_rise && busy_o)  trig_miss_o <= 1'b1;
      // a completed burst blocks restart until enable has been seen low
      if (!enable_i)            burst_done  <= 1'b0;

      case (state)
        IDLE: begin
          cnt    <= '0;
          stop_q <= 1'b0;
          if (enable_i && !burst_done) begin
            mode_q <= mode_i;
            case (mode_i)
              M_FREE:  state <= HIGH;
              M_TRIG:  state <= WAIT_TRIG;
              M_BURST: begin
                state     <= HIGH;
                burst_rem <= act_nx.burst - BURST_W'(1);
              end
              default: state <= IDLE;
            endcase
          end
        end

        WAIT_TRIG: begin
          cnt <= '0;
          if (!enable_i)      state <= IDLE;
          else if (trig_rise) state <= HIGH;
        end

        HIGH: begin
          cnt <= cnt + CNT_W'(1);
          if (!enable_i) stop_q <= 1'b1;
          // a started pulse always runs its full width
          if (hi_end) state <= (stop_q || !enable_i) ? IDLE : LOW;
        end

        LOW: begin
          if (!enable_i) begin
            state <= IDLE;
          end else if (lo_end) begin
            cnt <= '0;
            case (mode_q)
              M_FREE: state <= HIGH;
              M_TRIG: state <= WAIT_TRIG;
              M_BURST: begin
                if (burst_rem != '0) begin
                  state     <= HIGH;
                  burst_rem <= burst_rem - BURST_W'(1);
                end else begin
                  state      <= IDLE;
                  burst_done <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef FSIN_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt     <= '0;
      ts_o       <= '0;
      ts_valid_o <= 1'b0;
    end else begin
      ts_cnt     <= ts_cnt + 32'd1;
      ts_valid_o <= rise;
      if (rise) ts_o <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_fsin_sync_gen.sv
// Directed bench for fsin_sync_gen: config vector table plus timed sequences per run mode.
module tb_fsin_sync_gen;
  localparam int CNT_W   = 24;
  localparam int BURST_W = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable_i;
  logic [1:0]         mode_i;
  logic [CNT_W-1:0]   period_i;
  logic [CNT_W-1:0]   width_i;
  logic [BURST_W-1:0] burst_i;
  logic               cfg_load_i;
  logic               trig_i;
  logic               fsin_o;
  logic               busy_o;
  logic [31:0]        frame_cnt_o;
  logic               cfg_err_o;
  logic               trig_miss_o;
`ifdef FSIN_TIMESTAMP_EN
  logic [31:0]        ts_o;
  logic               ts_valid_o;
`endif

  int checks     = 0;
  int failures   = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  fsin_sync_gen #(.CNT_W(CNT_W), .PERIOD_DEF(20), .WIDTH_DEF(5), .BURST_W(BURST_W)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .mode_i(mode_i),
    .period_i(period_i), .width_i(width_i), .burst_i(burst_i),
    .cfg_load_i(cfg_load_i), .trig_i(trig_i), .fsin_o(fsin_o), .busy_o(busy_o),
    .frame_cnt_o(frame_cnt_o), .cfg_err_o(cfg_err_o), .trig_miss_o(trig_miss_o)
`ifdef FSIN_TIMESTAMP_EN
    , .ts_o(ts_o), .ts_valid_o(ts_valid_o)
`endif
  );

  typedef struct {
    int         period;
    int         width;
    int         burst;
    logic [1:0] mode;
    logic       exp_err;
  } cfg_vec_t;

  cfg_vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load(input int p, input int w, input int b);
    period_i   = p[CNT_W-1:0];
    width_i    = w[CNT_W-1:0];
    burst_i    = b[BURST_W-1:0];
    cfg_load_i = 1'b1;
    tick();
    cfg_load_i = 1'b0;
  endtask

  // Expected fsin_o after edge t, where edge 1 is the first edge that samples the start condition
  function automatic logic model(input int kind, input int t);
    case (kind)
      0: return t >= 2 && ((t - 2) % 20) < 5;
      1: return t >= 2 && ((t - 2) % 10) < 3;
      2: return (t < 12) ? (t >= 2 && ((t - 2) % 10) < 3) : (((t - 12) % 8) < 2);
      3: return t >= 2 && (t - 2) < 40 && ((t - 2) % 10) < 3;
      4: return (t >= 4 && t <= 6) || (t >= 24 && t <= 26);
      5: return t >= 2 && t <= 4;
      default: return 1'b0;
    endcase
  endfunction

  task automatic run(input int kind, input int ticks, input string name);
    logic prev = 1'b0;
    logic e;
    logic r;
`ifdef FSIN_TIMESTAMP_EN
    int          last_rise = -1;
    logic [31:0] last_ts   = '0;
`endif
    for (int t = 1; t <= ticks; t++) begin
      case (kind)
        2: begin
          if (t == 5) begin period_i = 10; width_i = 10; cfg_load_i = 1'b1; end
          if (t == 7) begin period_i = 8;  width_i = 2;  cfg_load_i = 1'b1; end
          if (t == 6 || t == 8) cfg_load_i = 1'b0;
        end
        4: begin
          if (t == 1 || t == 7 || t == 21)  trig_i = 1'b1;
          if (t == 4 || t == 10 || t == 25) trig_i = 1'b0;
        end
        5: if (t == 3) enable_i = 1'b0;
        default: ;
      endcase
      tick();
      e = model(kind, t);
      r = e && !prev;
      check($sformatf("%s_fsin_t%0d", name, t), 32'(fsin_o), 32'(e));
      if (r) exp_frames++;
`ifdef FSIN_TIMESTAMP_EN
      check($sformatf("%s_tsvld_t%0d", name, t), 32'(ts_valid_o), 32'(r));
      if (r) begin
        if (last_rise >= 0)
          check($sformatf("%s_tsdelta_t%0d", name, t), ts_o - last_ts, 32'(t - last_rise));
        last_ts   = ts_o;
        last_rise = t;
      end
`endif
      prev = e;
      case (kind)
        2: begin
          if (t == 5) check({name, "_err_set"}, 32'(cfg_err_o), 32'd1);
          if (t == 7) check({name, "_err_clr"}, 32'(cfg_err_o), 32'd0);
        end
        3: begin
          if (t == 40) check({name, "_busy_last"}, 32'(busy_o), 32'd1);
          if (t == 41) check({name, "_busy_done"}, 32'(busy_o), 32'd0);
        end
        4: begin
          if (t == 8) check({name, "_miss_pre"}, 32'(trig_miss_o), 32'd0);
          if (t == 9) check({name, "_miss_set"}, 32'(trig_miss_o), 32'd1);
        end
        5: begin
          if (t == 3) check({name, "_busy_hi"}, 32'(busy_o), 32'd1);
          if (t == 4) check({name, "_busy_idle"}, 32'(busy_o), 32'd0);
        end
        default: ;
      endcase
    end
    check({name, "_frames"}, frame_cnt_o, 32'(exp_frames));
  endtask

  task automatic stop(input string name);
    int n = 0;
    enable_i = 1'b0;
    do begin
      tick();
      n++;
    end while ((busy_o || fsin_o) && n < 40);
    check({name, "_idle"}, 32'(busy_o || fsin_o), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1,  1,  1, 2'b00, 1'b1};
    vecs[1] = '{2,  1,  1, 2'b00, 1'b0};
    vecs[2] = '{10, 0,  1, 2'b00, 1'b1};
    vecs[3] = '{10, 10, 1, 2'b00, 1'b1};
    vecs[4] = '{10, 11, 1, 2'b00, 1'b1};
    vecs[5] = '{10, 9,  1, 2'b00, 1'b0};
    vecs[6] = '{10, 3,  0, 2'b10, 1'b1};
    vecs[7] = '{10, 3,  0, 2'b00, 1'b0};
    vecs[8] = '{10, 3,  4, 2'b10, 1'b0};
    vecs[9] = '{0,  0,  7, 2'b00, 1'b1};

    reset = 1'b1; enable_i = 1'b0; mode_i = 2'b00; cfg_load_i = 1'b0; trig_i = 1'b0;
    period_i = '0; width_i = '0; burst_i = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_fsin",  32'(fsin_o),      32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_frame", frame_cnt_o,      32'd0);
    check("rst_err",   32'(cfg_err_o),   32'd0);
    check("rst_miss",  32'(trig_miss_o), 32'd0);

    // reset-default timing 20/5
    enable_i = 1'b1;
    run(0, 45, "dflt");
    stop("dflt");

    // free-run 10/3
    load(10, 3, 1);
    check("free_load_err", 32'(cfg_err_o), 32'd0);
    enable_i = 1'b1;
    run(1, 25, "free");
    stop("free");

    // reject while running, then an accepted load deferred to the boundary
    enable_i = 1'b1;
    run(2, 30, "recfg");
    stop("recfg");

    for (int i = 0; i < 10; i++) begin
      mode_i = vecs[i].mode;
      load(vecs[i].period, vecs[i].width, vecs[i].burst);
      check($sformatf("cfg_vec%0d", i), 32'(cfg_err_o), 32'(vecs[i].exp_err));
    end

    // burst of 4 at 10/3, held enable must not restart; re-arm via enable low
    mode_i = 2'b10;
    enable_i = 1'b1;
    run(3, 60, "burst1");
    enable_i = 1'b0;
    tick();
    tick();
    enable_i = 1'b1;
    run(3, 60, "burst2");
    stop("burst");

    // trigger mode
    mode_i = 2'b01;
    enable_i = 1'b1;
    repeat (3) tick();
    check("wait_trig_busy", 32'(busy_o), 32'd0);
    check("wait_trig_fsin", 32'(fsin_o), 32'd0);
    run(4, 30, "trig");
    stop("trig");

    // enable dropped mid-pulse
    mode_i = 2'b00;
    enable_i = 1'b1;
    run(5, 15, "abort");
    stop("abort");

    // reset in the middle of a pulse
    load(1, 1, 1);
    check("rst_pre_err", 32'(cfg_err_o), 32'd1);
    enable_i = 1'b1;
    tick();
    tick();
    check("rst_pre_fsin", 32'(fsin_o), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_fsin",  32'(fsin_o),      32'd0);
    check("midrst_busy",  32'(busy_o),      32'd0);
    check("midrst_frame", frame_cnt_o,      32'd0);
    check("midrst_err",   32'(cfg_err_o),   32'd0);
    check("midrst_miss",  32'(trig_miss_o), 32'd0);
`ifdef FSIN_TIMESTAMP_EN
    check("midrst_ts",    ts_o,             32'd0);
    check("midrst_tsvld", 32'(ts_valid_o),  32'd0);
`endif
    reset = 1'b0;
    enable_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
